// File: rtl/universal_shift_register_pkg.sv
// ============================================================================
// Module   : universal_shift_register_pkg
// Purpose  : Mode encodings shared by the universal shift register blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package universal_shift_register_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_ZERO = 3'b111;

endpackage

`default_nettype wire

// File: rtl/usr_next_state.sv
// ============================================================================
// Module   : usr_next_state
// Purpose  : Purely combinational next Q / next Carry for each shift mode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module usr_next_state
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  q_i,
  input  logic              carry_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              serial_in_l_i,
  input  logic              serial_in_r_i,
  output logic [WIDTH-1:0]  q_d_o,
  output logic              carry_d_o
);

  always_comb begin
    q_d_o     = q_i;
    carry_d_o = carry_i;
    // Serial inputs are only referenced in their own modes, so X on them stays contained.
    case (mode_i)
      MODE_HOLD: begin
        q_d_o     = q_i;
        carry_d_o = carry_i;
      end
      MODE_LOAD: begin
        q_d_o     = d_i;
        carry_d_o = 1'b0;
      end
      MODE_SHL: begin
        q_d_o     = {q_i[WIDTH-2:0], serial_in_l_i};
        carry_d_o = q_i[WIDTH-1];
      end
      MODE_SHR: begin
        q_d_o     = {serial_in_r_i, q_i[WIDTH-1:1]};
        carry_d_o = q_i[0];
      end
      MODE_ROL: begin
        q_d_o     = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        carry_d_o = q_i[WIDTH-1];
      end
      MODE_ROR: begin
        q_d_o     = {q_i[0], q_i[WIDTH-1:1]};
        carry_d_o = q_i[0];
      end
      MODE_ASR: begin
        q_d_o     = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        carry_d_o = q_i[0];
      end
      MODE_ZERO: begin
        q_d_o     = '0;
        carry_d_o = 1'b0;
      end
      default: begin
        q_d_o     = q_i;
        carry_d_o = carry_i;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/universal_shift_register.sv
// ============================================================================
// Module   : universal_shift_register
// Purpose  : WIDTH-bit hold/load/shift/rotate/zero register with carry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic              clock_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              serial_in_l_i,
  input  logic              serial_in_r_i,
  output logic [WIDTH-1:0]  q_o,
  output logic [WIDTH-1:0]  qbar_o,
  output logic              carry_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             carry_q;
  logic             carry_d;

  usr_next_state #(
    .WIDTH (WIDTH)
  ) u_next_state (
    .mode_i        (mode_i),
    .q_i           (q_q),
    .carry_i       (carry_q),
    .d_i           (d_i),
    .serial_in_l_i (serial_in_l_i),
    .serial_in_r_i (serial_in_r_i),
    .q_d_o         (q_d),
    .carry_d_o     (carry_d)
  );

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      q_q     <= RESET_VALUE;
      carry_q <= 1'b0;
    end else if (enable_i) begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  assign q_o     = q_q;
  assign qbar_o  = ~q_q;
  assign carry_o = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// ============================================================================
// Module   : tb_universal_shift_register
// Purpose  : Directed + random check of two register instances against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       clear, enable, sl, sr;
  logic [2:0] mode;
  logic [7:0] d;

  logic [7:0] qa, qbara, qb, qbarb;
  logic       ca, cb;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  // Model state for instance A (reset 0x00) and B (reset 0x3C)
  logic [7:0] ea = '0, eb = '0;
  logic       eca = 1'b0, ecb = 1'b0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut_a (
    .clock_i(clk), .clear_i(clear), .enable_i(enable), .mode_i(mode), .d_i(d),
    .serial_in_l_i(sl), .serial_in_r_i(sr), .q_o(qa), .qbar_o(qbara), .carry_o(ca)
  );

  universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h3C)) u_dut_b (
    .clock_i(clk), .clear_i(clear), .enable_i(enable), .mode_i(mode), .d_i(d),
    .serial_in_l_i(sl), .serial_in_r_i(sr), .q_o(qb), .qbar_o(qbarb), .carry_o(cb)
  );

  // Arithmetic description of one edge of the register.
  task automatic model_edge(input logic [7:0] rv, inout logic [7:0] q, inout logic c);
    int v;
    v = int'(q);
    if (clear) begin
      q = rv; c = 1'b0;
    end else if (enable) begin
      case (mode)
        3'd1: begin q = d; c = 1'b0; end
        3'd2: begin c = (v / 128) % 2 == 1; q = 8'((v * 2) % 256 + int'(sl)); end
        3'd3: begin c = v % 2 == 1; q = 8'(v / 2 + 128 * int'(sr)); end
        3'd4: begin c = (v / 128) % 2 == 1; q = 8'((v * 2) % 256 + v / 128); end
        3'd5: begin c = v % 2 == 1; q = 8'(v / 2 + 128 * (v % 2)); end
        3'd6: begin c = v % 2 == 1; q = 8'($signed(q) >>> 1); end
        3'd7: begin q = 8'h00; c = 1'b0; end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_edge(8'h00, ea, eca);
    model_edge(8'h3C, eb, ecb);
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp("model_qa", qa, ea);
      cmp("model_qbara", qbara, ~ea);
      cmp("model_ca", {7'd0, ca}, {7'd0, eca});
      cmp("model_qb", qb, eb);
      cmp("model_qbarb", qbarb, ~eb);
      cmp("model_cb", {7'd0, cb}, {7'd0, ecb});
    end
  end

  task automatic step(input logic c_, input logic e_, input logic [2:0] m_,
                      input logic [7:0] d_, input logic sl_, input logic sr_);
    clear = c_; enable = e_; mode = m_; d = d_; sl = sl_; sr = sr_;
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
  endtask

  task automatic lit(input string name, input logic [7:0] q, input logic c, input logic [7:0] eq, input logic ec);
    cmp({name, "_q"}, q, eq);
    cmp({name, "_c"}, {7'd0, c}, {7'd0, ec});
  endtask

  initial begin
    clear = 1'b0; enable = 1'b0; mode = 3'd0; d = '0; sl = 1'b0; sr = 1'b0;
    @(negedge clk);

    step(1, 0, 3'd0, 8'h00, 0, 0);
    lit("reset_a", qa, ca, 8'h00, 0);
    cmp("reset_qbar", qbara, 8'hFF);
    cmp("reset_b", qb, 8'h3C);

    step(0, 1, 3'd1, 8'hA5, 0, 0);
    lit("load_a5", qa, ca, 8'hA5, 0);
    cmp("load_qbar", qbara, 8'h5A);
    step(0, 1, 3'd2, 8'h00, 1, 0);
    lit("shl", qa, ca, 8'h4B, 1);
    step(0, 1, 3'd3, 8'h00, 0, 0);
    lit("shr", qa, ca, 8'h25, 1);

    step(0, 1, 3'd1, 8'hA5, 0, 0);
    step(0, 1, 3'd5, 8'h00, 0, 0);
    lit("ror", qa, ca, 8'hD2, 1);

    step(0, 1, 3'd1, 8'h81, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd4, 8'h00, 0, 0);
    lit("rol8", qa, ca, 8'h81, 1);

    step(0, 1, 3'd1, 8'h80, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd6, 8'h00, 1, 1);
    lit("asr3", qa, ca, 8'hF0, 0);
    step(0, 1, 3'd7, 8'h00, 1, 1);
    lit("zero", qa, ca, 8'h00, 0);

    step(0, 1, 3'd1, 8'h81, 0, 0);
    step(0, 1, 3'd4, 8'h00, 0, 0);
    lit("rol1", qa, ca, 8'h03, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 3'd1, 8'hFF, 1, 1);
    lit("en0_hold", qa, ca, 8'h03, 1);

    step(0, 1, 3'd2, 8'h00, 1, 0);
    step(0, 1, 3'd2, 8'h00, 1, 0);
    step(1, 1, 3'd2, 8'h00, 1, 0);
    lit("clr_mid_a", qa, ca, 8'h00, 0);
    lit("clr_mid_b", qb, cb, 8'h3C, 0);
    step(0, 1, 3'd2, 8'h00, 1, 0);
    lit("resume_a", qa, ca, 8'h01, 0);
    lit("resume_b", qb, cb, 8'h79, 0);
    step(0, 1, 3'd7, 8'h00, 0, 0);
    lit("zero_b", qb, cb, 8'h00, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 16) == 0, ($urandom % 4) != 0, 3'($urandom % 8),
           8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised WIDTH-bit register, the multi-bit successor to the single D flip-flop cell. It provides hold, parallel load, logical/arithmetic shift, rotate and synchronous zero modes, with complementary outputs and a registered carry bit. It serves as the general-purpose storage and shift element for datapath, serialiser and counter blocks in the design.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q on Clear
- Clock  input  1  sole clock; all state updates on the rising edge
- Clear  input  1  reset, synchronous, active-high; overrides all other inputs
- Enable  input  1  1 = perform Mode this edge; 0 = hold all state
- Mode  input  3  operation select; encodings in Operation
- D  input  WIDTH  parallel load data
- SerialInL  input  1  bit shifted into Q[0] on SHL
- SerialInR  input  1  bit shifted into Q[WIDTH-1] on SHR
- Q  output  WIDTH  register contents
- Qbar  output  WIDTH  bitwise complement of Q, always ~Q
- Carry  output  1  registered bit most recently shifted or rotated out

## Operation
- Priority at each rising Clock edge: Clear, then Enable=0 (hold), then Mode.
- Clear=1: Q <= RESET_VALUE, Carry <= 0. Enable and Mode are ignored.
- Mode encodings, applied when Enable=1:
  - 000 HOLD: Q and Carry unchanged.
  - 001 LOAD: Q <= D, Carry <= 0.
  - 010 SHL: Q <= {Q[WIDTH-2:0], SerialInL}, Carry <= Q[WIDTH-1].
  - 011 SHR: Q <= {SerialInR, Q[WIDTH-1:1]}, Carry <= Q[0].
  - 100 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}, Carry <= Q[WIDTH-1].
  - 101 ROR: Q <= {Q[0], Q[WIDTH-1:1]}, Carry <= Q[0].
  - 110 ASR: Q <= {Q[WIDTH-1], Q[WIDTH-1:1]}, Carry <= Q[0].
  - 111 ZERO: Q <= 0, Carry <= 0. This is a functional clear and ignores RESET_VALUE.
- Carry keeps its value across HOLD and Enable=0.
- Qbar is combinational from Q and never holds independent state.
- No X propagation from SerialInL or SerialInR in modes that do not use them.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on Q and Carry after edge N.
- Reset values: Q = RESET_VALUE, Qbar = ~RESET_VALUE, Carry = 0.
- Clear asserted mid-sequence, for example during a run of shifts: the register resets on that edge and shifting resumes from RESET_VALUE on the first edge with Clear=0.
- Clear=1 together with Enable=1: reset wins, and no shift or carry update occurs.
- Mode changes between consecutive edges are legal. Each edge acts only on the Mode sampled at that edge.
- Rotate wrap-around: WIDTH consecutive ROL or ROR operations return Q to its original value. Carry then equals the last bit rotated out.
- No combinational path from any input to Q or Carry. Qbar depends only on Q.

## Structure
- The shared package holds the mode constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR and MODE_ZERO, plus the mode width (3).
- Single module with a next-state combinational function and a Q/Carry register. Keeping it as one module is the natural structure.
- One sub-module is acceptable: usr_next_state, which is purely combinational. Its inputs are Mode, Q, D and the serial inputs; its outputs are next Q and next Carry. It is used so the next-state logic can be unit-checked on its own.

## Test plan
All scenarios use WIDTH=8 and RESET_VALUE=0x00.
- Clear=1 for one edge → Q=0x00, Qbar=0xFF, Carry=0; then LOAD D=0xA5 → Q=0xA5, Qbar=0x5A, Carry=0.
- From Q=0xA5, SHL with SerialInL=1 → Q=0x4B, Carry=1; then SHR with SerialInR=0 → Q=0x25, Carry=1.
- From Q=0xA5, ROR → Q=0xD2, Carry=1; eight ROL from 0x81 → Q=0x81, Carry=1.
- From Q=0x80, ASR three times → Q=0xF0, Carry=0; ZERO → Q=0x00, Carry=0.
- Enable=0 with Mode=LOAD and D=0xFF for 3 edges → Q and Carry unchanged.
- Clear=1 with Enable=1 and Mode=SHL mid-shift-run → Q=0x00, Carry=0 on that edge; rebuild with RESET_VALUE=0x3C → reset gives Q=0x3C, while ZERO still gives 0x00.
